pipe_stall_ctrl: RTL and testbench



---
 rtl/pipe_stall_ctrl.sv | 178 +++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for the 5-stage MIPS pipeline, with post-flush hold FSM and EX-stall watchdog.
// Optional performance counters are enabled by defining STALL_PERF_CNT_EN.
module pipe_stall_ctrl #(
  parameter logic [31:0] EXC_VECTOR        = 32'h0000_0020,
  parameter int unsigned FLUSH_HOLD_CYCLES = 2,
  parameter int unsigned MAX_STALL         = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic        busy_hold
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [15:0] perf_flush_count
`endif
);

  localparam logic [31:0] ERET_CODE  = 32'h0000_000e;
  localparam logic [3:0]  HOLD_LOAD  = 4'(FLUSH_HOLD_CYCLES);
  localparam logic [7:0]  STALL_MAX  = 8'(MAX_STALL);
  localparam logic [7:0]  STALL_LAST = 8'(MAX_STALL - 1);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e      state_q;
  logic [3:0]  hold_cnt_q;
  logic        busy_hold_q;
  logic [7:0]  stall_cnt_q;
  logic [7:0]  stall_cnt_d;
  logic        stall_timeout_q;
  logic        stall_timeout_d;
  logic        exc_s;

  assign exc_s = |excepttype_i;

  // Zero-latency stall/flush/redirect decode from current state and requests
  always_comb begin
    stall  = 6'b000000;
    flush  = 1'b0;
    new_pc = 32'h0000_0000;
    case (state_q)
      ST_RUN: begin
        if (exc_s) begin
          flush  = 1'b1;
          new_pc = (excepttype_i == ERET_CODE) ? epc_i : EXC_VECTOR;
        end else if (stallreq_ex) begin
          stall = 6'b001111;
        end else if (stallreq_id) begin
          stall = 6'b000111;
        end else begin
          stall = 6'b000000;
        end
      end
      ST_HOLD: begin
        stall  = 6'b000000;
        flush  = 1'b0;
        new_pc = 32'h0000_0000;
      end
      default: begin
        stall  = 6'b000000;
        flush  = 1'b0;
        new_pc = 32'h0000_0000;
      end
    endcase
  end

  // Run/hold FSM: a flush parks the pipeline for exactly FLUSH_HOLD_CYCLES bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      hold_cnt_q  <= 4'd0;
      busy_hold_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (exc_s) begin
            state_q     <= ST_HOLD;
            hold_cnt_q  <= HOLD_LOAD;
            busy_hold_q <= 1'b1;
          end else begin
            state_q     <= ST_RUN;
            hold_cnt_q  <= 4'd0;
            busy_hold_q <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (hold_cnt_q <= 4'd1) begin
            state_q     <= ST_RUN;
            hold_cnt_q  <= 4'd0;
            busy_hold_q <= 1'b0;
          end else begin
            state_q     <= ST_HOLD;
            hold_cnt_q  <= hold_cnt_q - 4'd1;
            busy_hold_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_RUN;
          hold_cnt_q  <= 4'd0;
          busy_hold_q <= 1'b0;
        end
      endcase
    end
  end

  // Watchdog next state: count consecutive EX stalls, saturate, latch the trip permanently
  always_comb begin
    stall_cnt_d     = 8'd0;
    stall_timeout_d = stall_timeout_q;
    if ((state_q == ST_RUN) && !exc_s && stallreq_ex) begin
      if (stall_cnt_q == STALL_LAST) begin
        stall_timeout_d = 1'b1;
      end else begin
        stall_timeout_d = stall_timeout_q;
      end
      if (stall_cnt_q >= STALL_MAX) begin
        stall_cnt_d = STALL_MAX;
      end else begin
        stall_cnt_d = stall_cnt_q + 8'd1;
      end
    end else begin
      stall_cnt_d = 8'd0;
    end
  end

  // Watchdog state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q     <= 8'd0;
      stall_timeout_q <= 1'b0;
    end else begin
      stall_cnt_q     <= stall_cnt_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end

  assign stall_timeout = stall_timeout_q;
  assign busy_hold     = busy_hold_q;

`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf_stall_q;
  logic [15:0] perf_flush_q;

  // Free-running wrap-around event counters for stalled and flushed cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 16'd0;
    end else begin
      if (stall != 6'b000000) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end else begin
        perf_stall_q <= perf_stall_q;
      end
      if (flush) begin
        perf_flush_q <= perf_flush_q + 16'd1;
      end else begin
        perf_flush_q <= perf_flush_q;
      end
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flush_count  = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed vector table, multi-cycle corner sequences
// and randomized traffic against a cycle-count reference model.
`timescale 1ns/1ps
module tb_pipe_stall_ctrl;

  localparam int HOLD_N = 2;
  localparam int MAX_ST = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic [31:0] excepttype_i;
  logic [31:0] epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic        busy_hold;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf_stall_cycles;
  logic [15:0] perf_flush_count;
`endif

  pipe_stall_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .excepttype_i (excepttype_i),
    .epc_i        (epc_i),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .stall_timeout(stall_timeout),
    .busy_hold    (busy_hold)
`ifdef STALL_PERF_CNT_EN
    ,
    .perf_stall_cycles(perf_stall_cycles),
    .perf_flush_count (perf_flush_count)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: cycles left in hold, length of the current EX-stall run, sticky trip flag
  int          m_hold_left;
  int          m_run_len;
  bit          m_timeout;
  logic [31:0] m_perf_stall;
  logic [15:0] m_perf_flush;

  typedef struct {
    logic        id;
    logic        ex;
    logic [31:0] exc;
    logic [31:0] epc;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_busy;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_hold_left  = 0;
    m_run_len    = 0;
    m_timeout    = 1'b0;
    m_perf_stall = 32'd0;
    m_perf_flush = 16'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; stallreq_id = 1'b0; stallreq_ex = 1'b0; excepttype_i = 32'h0; epc_i = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One cycle: drive, compare everything against the model, advance the model over the coming edge
  task automatic step(input logic id, input logic ex, input logic [31:0] exc, input logic [31:0] epc);
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    @(negedge clk);
    stallreq_id = id; stallreq_ex = ex; excepttype_i = exc; epc_i = epc;
    #1;
    e_stall = 6'b000000; e_flush = 1'b0; e_pc = 32'h0;
    if (m_hold_left == 0) begin
      if (exc != 32'h0) begin
        e_flush = 1'b1;
        e_pc    = (exc == 32'h0000_000e) ? epc : 32'h0000_0020;
      end else if (ex) e_stall = 6'b001111;
      else if (id)     e_stall = 6'b000111;
    end
    check("stall",  {26'h0, stall}, {26'h0, e_stall});
    check("flush",  {31'h0, flush}, {31'h0, e_flush});
    check("new_pc", new_pc, e_pc);
    check("busy_hold", {31'h0, busy_hold}, {31'h0, (m_hold_left != 0)});
    check("stall_timeout", {31'h0, stall_timeout}, {31'h0, m_timeout});
`ifdef STALL_PERF_CNT_EN
    check("perf_stall_cycles", perf_stall_cycles, m_perf_stall);
    check("perf_flush_count", {16'h0, perf_flush_count}, {16'h0, m_perf_flush});
`endif
    if (e_stall != 6'b000000) m_perf_stall = m_perf_stall + 32'd1;
    if (e_flush) m_perf_flush = m_perf_flush + 16'd1;
    if (m_hold_left != 0) begin
      m_hold_left--;
      m_run_len = 0;
    end else if (exc != 32'h0) begin
      m_hold_left = HOLD_N;
      m_run_len   = 0;
    end else if (ex) begin
      m_run_len++;
      if (m_run_len >= MAX_ST) m_timeout = 1'b1;
    end else begin
      m_run_len = 0;
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 32'h0, 32'h0,      6'b000000, 1'b0, 32'h0,      1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0, 32'h0,      6'b000111, 1'b0, 32'h0,      1'b0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0, 32'h0,      6'b000000, 1'b0, 32'h0,      1'b0};
    vecs[3]  = '{1'b1, 1'b1, 32'h0, 32'h0,      6'b001111, 1'b0, 32'h0,      1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'h0, 32'h0,      6'b001111, 1'b0, 32'h0,      1'b0};
    vecs[5]  = '{1'b0, 1'b1, 32'h8, 32'h5555,   6'b000000, 1'b1, 32'h20,     1'b0};
    vecs[6]  = '{1'b1, 1'b1, 32'hc, 32'h0,      6'b000000, 1'b0, 32'h0,      1'b1};
    vecs[7]  = '{1'b0, 1'b0, 32'h0, 32'h0,      6'b000000, 1'b0, 32'h0,      1'b1};
    vecs[8]  = '{1'b1, 1'b0, 32'h0, 32'h0,      6'b000111, 1'b0, 32'h0,      1'b0};
    vecs[9]  = '{1'b0, 1'b0, 32'he, 32'h1234,   6'b000000, 1'b1, 32'h1234,   1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'h0, 32'h0,      6'b000000, 1'b0, 32'h0,      1'b1};
    vecs[11] = '{1'b1, 1'b0, 32'h0, 32'h0,      6'b000000, 1'b0, 32'h0,      1'b1};
    vecs[12] = '{1'b0, 1'b0, 32'h0, 32'h0,      6'b000000, 1'b0, 32'h0,      1'b0};

    do_reset();
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].id, vecs[i].ex, vecs[i].exc, vecs[i].epc);
      check($sformatf("vec%0d_stall", i), {26'h0, stall}, {26'h0, vecs[i].e_stall});
      check($sformatf("vec%0d_flush", i), {31'h0, flush}, {31'h0, vecs[i].e_flush});
      check($sformatf("vec%0d_new_pc", i), new_pc, vecs[i].e_pc);
      check($sformatf("vec%0d_busy", i), {31'h0, busy_hold}, {31'h0, vecs[i].e_busy});
    end

    // Watchdog trips after exactly MAX_STALL consecutive EX stalls and stays set
    do_reset();
    for (int i = 0; i < MAX_ST; i++) step(1'b0, 1'b1, 32'h0, 32'h0);
    check("wd_not_before_edge", {31'h0, stall_timeout}, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    check("wd_tripped", {31'h0, stall_timeout}, 32'h1);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    check("wd_sticky", {31'h0, stall_timeout}, 32'h1);
    step(1'b0, 1'b1, 32'h0, 32'h0);
    check("wd_stall_continues", {26'h0, stall}, 32'h0000000f);

    // Two runs of MAX_STALL-1 separated by one gap never trip
    do_reset();
    check("wd_cleared_by_rst", {31'h0, stall_timeout}, 32'h0);
    for (int i = 0; i < MAX_ST - 1; i++) step(1'b0, 1'b1, 32'h0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < MAX_ST - 1; i++) step(1'b0, 1'b1, 32'h0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    check("wd_gap_no_trip", {31'h0, stall_timeout}, 32'h0);

    // Exception interrupting a long stall run clears the watchdog count
    do_reset();
    for (int i = 0; i < MAX_ST - 2; i++) step(1'b0, 1'b1, 32'h0, 32'h0);
    step(1'b0, 1'b1, 32'h4, 32'h0);
    for (int i = 0; i < HOLD_N + MAX_ST - 1; i++) step(1'b0, 1'b1, 32'h0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    check("wd_exc_clears", {31'h0, stall_timeout}, 32'h0);

`ifdef STALL_PERF_CNT_EN
    do_reset();
    for (int i = 0; i < 10; i++) step(i[0], ~i[0], 32'h0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 32'h8, 32'h0);
      for (int j = 0; j < HOLD_N; j++) step(1'b0, 1'b0, 32'h0, 32'h0);
    end
    step(1'b0, 1'b0, 32'h0, 32'h0);
    check("perf_stall_10", perf_stall_cycles, 32'd10);
    check("perf_flush_2", {16'h0, perf_flush_count}, 32'd2);
    step(1'b0, 1'b0, 32'he, 32'h40);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    do_reset();
    #1;
    check("rst_hold_busy", {31'h0, busy_hold}, 32'h0);
    check("rst_perf_stall", perf_stall_cycles, 32'd0);
    check("rst_perf_flush", {16'h0, perf_flush_count}, 32'd0);
`endif

    // Reset while in HOLD returns to RUN immediately
    step(1'b0, 1'b0, 32'hc, 32'h0);
    do_reset();
    step(1'b1, 1'b0, 32'h0, 32'h0);
    check("rst_mid_hold_run", {26'h0, stall}, 32'h00000007);

    // Randomized traffic with occasional long EX bursts and resets
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] exc;
      logic        ex;
      exc = 32'h0;
      if ($urandom_range(0, 24) == 0) begin
        case ($urandom_range(0, 3))
          0: exc = 32'h8;
          1: exc = 32'hc;
          2: exc = 32'he;
          default: exc = $urandom() | 32'h1;
        endcase
      end
      ex = ($urandom_range(0, 9) < 7);
      if ((n % 700) > 600) begin
        ex  = 1'b1;
        exc = 32'h0;
      end
      if ($urandom_range(0, 999) == 0) do_reset();
      step($urandom_range(0, 1) == 1, ex, exc, $urandom());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
